// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared constants and types for fifo_stream_reader.
package fifo_stream_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0]  skid_cnt_t;
    typedef logic [15:0] beat_cnt_t;
    typedef logic [31:0] stat_cnt_t;

    // Saturating increment for the statistics counters.
    function automatic stat_cnt_t stat_inc(input stat_cnt_t v);
        return (v == '1) ? v : v + stat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// fifo_stream_skid: 2-entry in-order valid/ready buffer. The head entry is
// a register that drives the stream data directly, so data is stable while
// the consumer stalls. The caller never pushes into a full buffer without
// popping in the same cycle, and never pops an empty one.
module fifo_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output skid_cnt_t         count,
    output logic [DWIDTH-1:0] head_data,
    output logic              valid
);

    logic [DWIDTH-1:0] tail_data;

    // Entry storage and occupancy; the tail shifts into the head on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == skid_cnt_t'(0)) head_data <= push_data;
                    else                         tail_data <= push_data;
                    count <= count + skid_cnt_t'(1);
                end
                2'b01: begin
                    head_data <= tail_data;
                    count     <= count - skid_cnt_t'(1);
                end
                2'b11: begin
                    if (count == skid_cnt_t'(1)) begin
                        head_data <= push_data;
                    end else begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count != skid_cnt_t'(0));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a synchronous FIFO read port and
// presents them as a valid/ready stream with a per-packet last flag.
// FIFO read latency (FWFT=1 same cycle, FWFT=0 next cycle) is absorbed by a
// 2-entry buffer so a ready consumer sees one beat per cycle.
// Optional statistics outputs are built when FIFO_STREAM_READER_STATS_EN is
// defined.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int FWFT    = 1,
    parameter int PKT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              empty_i,
    output logic              rd_o,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output stat_cnt_t         stat_beats_o,
    output stat_cnt_t         stat_pkts_o,
    output stat_cnt_t         stat_stall_o
`endif
);

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(PKT_LEN - 1);

    skid_cnt_t count;
    skid_cnt_t occupancy;
    beat_cnt_t beat_cnt;
    logic      inflight;
    logic      push;
    logic      pop;

    assign pop       = m_valid_o && m_ready_i;
    assign occupancy = count + skid_cnt_t'(inflight);

    // A read is allowed while a slot is free counting the in-flight word, or
    // when a pop this cycle frees one. rst_n gates the strobe so nothing is
    // read from the FIFO while the buffer is held in reset.
    assign rd_o = rst_n && en_i && !empty_i &&
                  ((occupancy < skid_cnt_t'(SKID_DEPTH)) || pop);

    generate
        if (FWFT != 0) begin : g_fwft
            assign inflight = 1'b0;
            assign push     = rd_o;
        end else begin : g_reg
            // Registered FIFO: the word requested this cycle arrives next cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) inflight <= 1'b0;
                else        inflight <= rd_o;
            end
            assign push = inflight;
        end
    endgenerate

    fifo_stream_skid #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_i),
        .pop       (pop),
        .count     (count),
        .head_data (m_data_o),
        .valid     (m_valid_o)
    );

    // Beat position within the current packet; advances only on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  beat_cnt <= '0;
        else if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + beat_cnt_t'(1);
    end

    assign m_last_o = m_valid_o && (beat_cnt == LAST_BEAT);

`ifdef FIFO_STREAM_READER_STATS_EN
    // Saturating counters for delivered beats, packets and stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats_o <= '0;
            stat_pkts_o  <= '0;
            stat_stall_o <= '0;
        end else begin
            if (pop)                     stat_beats_o <= stat_inc(stat_beats_o);
            if (pop && m_last_o)         stat_pkts_o  <= stat_inc(stat_pkts_o);
            if (m_valid_o && !m_ready_i) stat_stall_o <= stat_inc(stat_stall_o);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: two DUTs (lane 0 FWFT=0, lane 1 FWFT=1, PKT_LEN=4)
// share en/ready and identical FIFO contents. A per-cycle model predicts
// rd/valid/data/last from the FIFO read order and arrival latency; directed
// literal checks pin latency, ordering, last placement and reset behaviour.
module tb_fifo_stream_reader;

    localparam int PKT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic ready = 1'b0;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    // Shared FIFO contents; each lane has its own read pointer.
    logic [31:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr [2] = '{0, 0};
    logic [31:0] dreg = '0;

    logic        empty [2];
    logic [31:0] din   [2];
    logic        rd    [2];
    logic        vld   [2];
    logic        lst   [2];
    logic [31:0] md    [2];
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0] sb [2];
    logic [31:0] sp [2];
    logic [31:0] ss [2];
`endif

    assign empty[0] = (rd_ptr[0] == wr_ptr);
    assign empty[1] = (rd_ptr[1] == wr_ptr);
    assign din[0]   = dreg;
    assign din[1]   = fifo_mem[rd_ptr[1] & 63];

    for (genvar g = 0; g < 2; g++) begin : lane
        fifo_stream_reader #(.DWIDTH(32), .FWFT(g), .PKT_LEN(PKT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en),
            .data_i    (din[g]),
            .empty_i   (empty[g]),
            .rd_o      (rd[g]),
            .m_data_o  (md[g]),
            .m_valid_o (vld[g]),
            .m_last_o  (lst[g]),
            .m_ready_i (ready)
`ifdef FIFO_STREAM_READER_STATS_EN
            ,
            .stat_beats_o (sb[g]),
            .stat_pkts_o  (sp[g]),
            .stat_stall_o (ss[g])
`endif
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO behaviour: pointer advance on read, registered data for lane 0.
    always @(posedge clk) begin
        if (rd[0] && !empty[0]) begin
            dreg      <= fifo_mem[rd_ptr[0] & 63];
            rd_ptr[0] <= rd_ptr[0] + 1;
        end
        if (rd[1] && !empty[1]) rd_ptr[1] <= rd_ptr[1] + 1;
    end

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d @cyc %0d: got %0h, want %0h", nm, g, cyc, act, exp);
        end
    endtask

    // Model state: outstanding words (read but not popped) with arrival cycle.
    logic [31:0] ent_d [2][64];
    int          ent_a [2][64];
    int          qh [2] = '{0, 0};
    int          qt [2] = '{0, 0};
    int          beats [2] = '{0, 0};
    int          mb [2] = '{0, 0};
    int          mp [2] = '{0, 0};
    int          ms [2] = '{0, 0};
    // Logs used by the directed checks.
    logic [31:0] pop_d [2][64];
    logic        pop_l [2][64];
    int          pop_c [2][64];
    int          npop [2] = '{0, 0};
    int          rdc [2][64];
    int          nrd [2] = '{0, 0};

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) begin
                    qh[g] = qt[g];
                    beats[g] = 0;
                    mb[g] = 0; mp[g] = 0; ms[g] = 0;
                end else begin
                    logic ev, ep, er, el;
                    ev = (qt[g] != qh[g]) && (ent_a[g][qh[g] & 63] <= cyc);
                    ep = ev && ready;
                    er = en && !empty[g] && (((qt[g] - qh[g]) < 2) || ep);
                    el = ev && ((beats[g] % PKT) == PKT - 1);
                    check("rd_o", g, 32'(rd[g]), 32'(er));
                    check("m_valid_o", g, 32'(vld[g]), 32'(ev));
                    check("m_last_o", g, 32'(lst[g]), 32'(el));
                    if (ev) check("m_data_o", g, md[g], ent_d[g][qh[g] & 63]);
                    if (rd[g] && empty[g]) check("rd_while_empty", g, 32'(1), 32'(0));
`ifdef FIFO_STREAM_READER_STATS_EN
                    check("stat_beats", g, sb[g], 32'(mb[g]));
                    check("stat_pkts", g, sp[g], 32'(mp[g]));
                    check("stat_stall", g, ss[g], 32'(ms[g]));
`endif
                    if (ev && !ready) ms[g]++;
                    if (rd[g]) begin
                        rdc[g][nrd[g] & 63] = cyc;
                        nrd[g]++;
                    end
                    if (ep) begin
                        pop_d[g][npop[g] & 63] = ent_d[g][qh[g] & 63];
                        pop_l[g][npop[g] & 63] = el;
                        pop_c[g][npop[g] & 63] = cyc;
                        npop[g]++;
                        qh[g]++;
                        beats[g]++;
                        mb[g]++;
                        if (el) mp[g]++;
                    end
                    if (er) begin
                        ent_d[g][qt[g] & 63] = fifo_mem[rd_ptr[g] & 63];
                        ent_a[g][qt[g] & 63] = cyc + ((g == 0) ? 2 : 1);
                        qt[g]++;
                    end
                end
            end
        end
    end

    task automatic load(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_mem[wr_ptr & 63] = first + 32'(k);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait until both lanes have delivered the given pop totals.
    task automatic wait_pops(input string nm, input int t0, input int t1);
        for (int k = 0; k < 80; k++) begin
            if (npop[0] >= t0 && npop[1] >= t1) break;
            tick(1);
        end
        tick(2);
        check({nm, "_pops"}, 0, 32'(npop[0]), 32'(t0));
        check({nm, "_pops"}, 1, 32'(npop[1]), 32'(t1));
    endtask

    int b[2];
    int r[2];

    initial begin
        // Reset state.
        tick(3);
        for (int g = 0; g < 2; g++) begin
            check("rst_valid", g, 32'(vld[g]), 32'(0));
            check("rst_last", g, 32'(lst[g]), 32'(0));
            check("rst_rd", g, 32'(rd[g]), 32'(0));
            check("rst_data", g, md[g], 32'h0);
        end
        rst_n = 1'b1;
        tick(1);

        // A: 8 words, full throughput.
        load(32'h1, 8);
        for (int g = 0; g < 2; g++) begin b[g] = npop[g]; r[g] = nrd[g]; end
        ready = 1'b1;
        en = 1'b1;
        wait_pops("A", b[0] + 8, b[1] + 8);
        for (int g = 0; g < 2; g++) begin
            check("A_latency", g, 32'(pop_c[g][b[g]] - rdc[g][r[g]]), (g == 0) ? 32'd2 : 32'd1);
            check("A_no_bubble", g, 32'(pop_c[g][b[g] + 7] - pop_c[g][b[g]]), 32'd7);
            for (int k = 0; k < 8; k++) check("A_order", g, pop_d[g][b[g] + k], 32'(k + 1));
            check("A_last4", g, 32'(pop_l[g][b[g] + 3]), 32'd1);
            check("A_last8", g, 32'(pop_l[g][b[g] + 7]), 32'd1);
        end

        // C: 12 beats, en low for 3 cycles with words waiting between 6 and 7.
        for (int g = 0; g < 2; g++) b[g] = npop[g];
        load(32'h21, 6);
        wait_pops("C1", b[0] + 6, b[1] + 6);
        en = 1'b0;
        load(32'h27, 6);
        tick(3);
        for (int g = 0; g < 2; g++) check("C_en_low_no_rd", g, 32'(nrd[g]), 32'(r[g] + 14));
        en = 1'b1;
        wait_pops("C2", b[0] + 12, b[1] + 12);
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 12; k++)
                check("C_last", g, 32'(pop_l[g][b[g] + k]), 32'((k % 4) == 3));

        // B: backpressure for 5 cycles mid-stream.
        for (int g = 0; g < 2; g++) b[g] = npop[g];
        load(32'h30, 10);
        tick(3);
        ready = 1'b0;
        tick(5);
        for (int g = 0; g < 2; g++) begin
            check("B_stall_valid", g, 32'(vld[g]), 32'd1);
            check("B_stall_rd", g, 32'(rd[g]), 32'd0);
        end
        ready = 1'b1;
        wait_pops("B", b[0] + 10, b[1] + 10);
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 10; k++) check("B_order", g, pop_d[g][b[g] + k], 32'h30 + 32'(k));

        // D: FIFO runs empty after 3 words.
        for (int g = 0; g < 2; g++) b[g] = npop[g];
        load(32'h50, 3);
        wait_pops("D", b[0] + 3, b[1] + 3);
        tick(2);
        for (int g = 0; g < 2; g++) begin
            check("D_idle_valid", g, 32'(vld[g]), 32'd0);
            check("D_idle_rd", g, 32'(rd[g]), 32'd0);
            check("D_beat3", g, pop_d[g][b[g] + 2], 32'h52);
        end

        // E: async reset with a full buffer.
        ready = 1'b0;
        load(32'h60, 8);
        tick(4);
        for (int g = 0; g < 2; g++) check("E_full_valid", g, 32'(vld[g]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("E_rst_valid", g, 32'(vld[g]), 32'd0);
            check("E_rst_last", g, 32'(lst[g]), 32'd0);
            check("E_rst_rd", g, 32'(rd[g]), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
            check("E_rst_stat_beats", g, sb[g], 32'd0);
            check("E_rst_stat_pkts", g, sp[g], 32'd0);
            check("E_rst_stat_stall", g, ss[g], 32'd0);
`endif
        end
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        for (int g = 0; g < 2; g++) b[g] = npop[g];
        wait_pops("E", b[0] + 6, b[1] + 6);
        for (int g = 0; g < 2; g++) begin
            check("E_first_after_rst", g, pop_d[g][b[g]], 32'h62);
            for (int k = 0; k < 4; k++) check("E_last", g, 32'(pop_l[g][b[g] + k]), 32'(k == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
